// File: rtl/demux32_8_if.sv
// Word-in / byte-out handshake bundle for the 32-to-8 unpacker.
// The master side drives both the upstream word lane and the downstream ready.
interface demux32_8_if #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 4
);
  logic [BYTE_W*NUM_BYTES-1:0] data_in;
  logic                        valid_in;
  logic                        ready_out;
  logic [BYTE_W-1:0]           data_out;
  logic                        valid_out;
  logic                        ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );
endinterface

// File: rtl/demux32_8.sv
// Unpacks words into bytes, MSB byte first, through a 2-word holding FIFO
// feeding a registered byte output stage; one byte per clock when unstalled.
module demux32_8 #(
  parameter int BYTE_W     = 8,
  parameter int NUM_BYTES  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_4f,
  input  logic        reset,
  demux32_8_if.slave  bus
);
  localparam int WORD_W = BYTE_W * NUM_BYTES;
  localparam int IDX_W  = $clog2(NUM_BYTES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Byte i of a word, counting from the most significant end.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] sh;
    sh = w << (int'(i) * BYTE_W);
    return sh[WORD_W-1 -: BYTE_W];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  logic ready, push, adv, load, pop;

  // ready_out looks only at registered occupancy, so it never waits on ready_in.
  assign ready = !reset && (count_q != FULL_CNT);
  assign push  = bus.valid_in && ready;
  assign adv   = !valid_out_q || bus.ready_in;
  assign load  = adv && (count_q != '0);
  assign pop   = load && (idx_q == LAST_IDX);

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;

    if (adv) begin
      valid_out_d = load;
      if (load) begin
        data_out_d = byte_sel(mem_q[rd_ptr_q], idx_q);
        idx_d      = pop ? '0 : idx_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      idx_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Word storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk_4f) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.ready_out = ready;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_demux32_8.sv
// Scoreboard bench for demux32_8: accepted words expand into a byte queue,
// and a negedge monitor checks every presented byte, ready_out and continuity.
module tb_demux32_8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy_rand = 1'b0;
  logic rdy_man = 1'b1;
  logic rnd_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int old_size = 0;

  demux32_8_if #(.BYTE_W(8), .NUM_BYTES(4)) bus ();

  demux32_8 #(.BYTE_W(8), .NUM_BYTES(4), .FIFO_DEPTH(2)) dut (
    .clk_4f (clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.ready_in = rdy_rand ? rnd_rdy : rdy_man;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: everything here is sampled mid-cycle, so it describes the next edge.
  always @(negedge clk) begin
    int unloaded;
    int exp_cnt;
    logic [31:0] w;
    if (reset) begin
      exp_q.delete();
      old_size = 0;
      chk("rst_valid_out", {31'b0, bus.valid_out}, 32'd0);
      chk("rst_ready_out", {31'b0, bus.ready_out}, 32'd0);
    end else begin
      unloaded = exp_q.size() - (bus.valid_out ? 1 : 0);
      if (unloaded < 0) unloaded = 0;
      exp_cnt = (unloaded + 3) / 4;
      chk("ready_out", {31'b0, bus.ready_out}, {31'b0, (exp_cnt != 2)});
      if (old_size > 0)
        chk("no_gap_valid", {31'b0, bus.valid_out}, 32'd1);
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected no valid byte at %0t",
                   bus.data_out, $time);
        end else begin
          chk("data_out", {24'b0, bus.data_out}, {24'b0, exp_q[0]});
          if (bus.ready_in) void'(exp_q.pop_front());
        end
      end
      old_size = exp_q.size();
      if (bus.valid_in && bus.ready_out) begin
        w = bus.data_in;
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit done = 0;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: word %h not accepted within 100 cycles", w);
    end
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.valid_out) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_byte(input logic [7:0] b);
    bit done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bus.valid_out && bus.data_out == b) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: got %h expected %h", bus.data_out, b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    #2;
    chk("reset_data_out",  {24'b0, bus.data_out}, 32'd0);
    chk("reset_valid_out", {31'b0, bus.valid_out}, 32'd0);
    chk("reset_ready_out", {31'b0, bus.ready_out}, 32'd0);
    #21 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single word, then the output goes idle but keeps the last byte.
    send_word(32'hAABBCCDD);
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("single_idle_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("single_hold_data",  {24'b0, bus.data_out}, 32'h0000_00DD);
    wait_drain();

    // Back-to-back words.
    send_word(32'h01020304);
    send_word(32'h05060708);
    bus.valid_in = 1'b0;
    wait_drain();

    // Full FIFO under backpressure; a third word must be refused.
    rdy_man = 1'b0;
    send_word(32'h11223344);
    send_word(32'h55667788);
    bus.data_in = 32'h99AABBCC;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready_out", {31'b0, bus.ready_out}, 32'd0);
      chk("full_hold_data", {24'b0, bus.data_out}, 32'h0000_0011);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    rdy_man = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("drained_ready_out", {31'b0, bus.ready_out}, 32'd1);
    @(posedge clk);
    #1;

    // Stall for three cycles while AD is presented.
    send_word(32'hDEADBEEF);
    bus.valid_in = 1'b0;
    wait_byte(8'hDE);
    @(posedge clk);
    #1;
    rdy_man = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_data", {24'b0, bus.data_out}, 32'h0000_00AD);
      @(posedge clk);
      #1;
    end
    rdy_man = 1'b1;
    wait_drain();

    // Asynchronous reset after BB is presented.
    send_word(32'hAABBCCDD);
    bus.valid_in = 1'b0;
    wait_byte(8'hBB);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("async_rst_ready", {31'b0, bus.ready_out}, 32'd0);
    chk("async_rst_data",  {24'b0, bus.data_out}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_word(32'h0A0B0C0D);
    bus.valid_in = 1'b0;
    wait_drain();

    // Push lands on the same edge that pops the head word (idx at last byte).
    send_word(32'h21222324);
    idle(3);
    send_word(32'h31323334);
    bus.valid_in = 1'b0;
    wait_drain();

    // Randomized words, gaps and downstream backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      send_word($urandom);
    end
    bus.valid_in = 1'b0;
    wait_drain();
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
